ahb_spi_cmd_frontend: RTL and testbench

AHB-Lite slave front end of the AHB-to-SPI bridge, in the HCLK domain, directly upstream of the command async FIFO and downstream of the response async FIFO. Converts each accepted AHB-Lite transfer into one 41-bit command entry pushed into the command FIFO write port. For reads, it stalls the bus until the SPI side returns a 32-bit word through the response FIFO read port. Unsupported transfers get a two-cycle ERROR response.

---
 rtl/ahb_spi_cmd_frontend.sv | 174 +++++++++++++++++
 tb/tb_ahb_spi_cmd_frontend.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_spi_cmd_frontend.sv
// ---------------------------------------------------------------------------
// ahb_spi_cmd_frontend
//
// AHB-Lite slave front end of the AHB-to-SPI bridge (HCLK domain). Every
// accepted legal transfer becomes one 41-bit entry {write, addr[7:0], data}
// pushed into the command FIFO. Reads hold the bus (HREADYOUT low) until the
// SPI side returns a word through the response FIFO. Transfers that are not
// 32-bit and word aligned get the two-cycle ERROR response.
//
// Optional feature, macro AHB_RD_TIMEOUT_EN:
//   RD_WAIT gives up after TIMEOUT_CYCLES cycles and answers ERROR. Each
//   abandoned read is remembered in a saturating 4-bit discard counter so
//   that its late response is popped and dropped instead of being returned
//   to a later read. Without the macro RD_WAIT waits indefinitely.
//
// Ports
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS,
//   HWRITE, HSIZE,
//   HWDATA, HREADY       AHB-Lite slave inputs (only HADDR[7:0] is carried)
//   HREADYOUT, HRESP,
//   HRDATA               AHB-Lite slave outputs
//   cmd_wr_en/_data      command FIFO write port, cmd_full its full flag
//   rsp_rd_en            response FIFO pop, rsp_data valid the cycle after
//   rsp_empty            response FIFO empty flag
// ---------------------------------------------------------------------------
module ahb_spi_cmd_frontend #(
  parameter int ADDR_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        cmd_wr_en,
  output logic [40:0] cmd_wr_data,
  input  logic        cmd_full,
  output logic        rsp_rd_en,
  input  logic [31:0] rsp_data,
  input  logic        rsp_empty
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD_PUSH, S_RD_WAIT, S_RD_CAPT, S_ERR1, S_ERR2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   accept;
  logic                   legal;
  logic                   take;

  // NONSEQ and SEQ both have HTRANS[1] set; IDLE/BUSY are ignored.
  assign accept = HSEL & HREADY & HTRANS[1];
  assign legal  = (HSIZE == 3'b010) && (HADDR[1:0] == 2'b00);

  logic unused_ok;
  assign unused_ok = ^{HADDR[31:ADDR_BITS], HTRANS[0], 32'(TIMEOUT_CYCLES)};

`ifdef AHB_RD_TIMEOUT_EN
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);
  logic [9:0] tmr_q;
  logic [3:0] disc_q;
  logic       timeout;
  logic       drop;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    take        = 1'b0;
    HREADYOUT   = 1'b1;
    HRESP       = 1'b0;
    HRDATA      = '0;
    cmd_wr_en   = 1'b0;
    cmd_wr_data = '0;
    rsp_rd_en   = 1'b0;
`ifdef AHB_RD_TIMEOUT_EN
    timeout     = 1'b0;
    // A response owed to an abandoned read is the oldest one in the FIFO;
    // it is dropped whatever state we are in.
    drop        = (disc_q != 4'd0) && !rsp_empty;
    rsp_rd_en   = drop;
`endif

    case (state_q)
      S_IDLE: take = 1'b1;
      S_WR: begin
        HREADYOUT   = !cmd_full;
        cmd_wr_en   = !cmd_full;
        cmd_wr_data = {1'b1, addr_q, HWDATA};
        if (!cmd_full) begin
          state_d = S_IDLE;
          take    = 1'b1;
        end
      end
      S_RD_PUSH: begin
        HREADYOUT   = 1'b0;
        cmd_wr_en   = !cmd_full;
        cmd_wr_data = {1'b0, addr_q, 32'h0};
        if (!cmd_full) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        HREADYOUT = 1'b0;
`ifdef AHB_RD_TIMEOUT_EN
        if (!drop) begin
          if (!rsp_empty) begin
            rsp_rd_en = 1'b1;
            state_d   = S_RD_CAPT;
          end else if (tmr_q == TMO_LAST) begin
            timeout = 1'b1;
            state_d = S_ERR1;
          end
        end
`else
        if (!rsp_empty) begin
          rsp_rd_en = 1'b1;
          state_d   = S_RD_CAPT;
        end
`endif
      end
      S_RD_CAPT: begin
        HRDATA = rsp_data;
        take   = 1'b1;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = S_ERR2;
      end
      S_ERR2: begin
        // The master cancels whatever it presents here after seeing ERROR.
        HRESP   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Address phase overlapping a completing data phase.
    if (take && accept) begin
      addr_d  = HADDR[ADDR_BITS-1:0];
      state_d = !legal ? S_ERR1 : (HWRITE ? S_WR : S_RD_PUSH);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
`ifdef AHB_RD_TIMEOUT_EN
      tmr_q   <= '0;
      disc_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
`ifdef AHB_RD_TIMEOUT_EN
      tmr_q   <= (state_q == S_RD_WAIT) ? tmr_q + 10'd1 : 10'd0;
      // timeout needs an empty FIFO and drop a non-empty one: never both.
      if (timeout && (disc_q != 4'hF)) disc_q <= disc_q + 4'd1;
      else if (drop)                   disc_q <= disc_q - 4'd1;
`endif
    end
  end

endmodule

// File: tb/tb_ahb_spi_cmd_frontend.sv
`timescale 1ns/1ps
module tb_ahb_spi_cmd_frontend;

  logic        HCLK = 1'b0, HRESETn = 1'b0, HSEL = 1'b0, HWRITE = 1'b0;
  logic [31:0] HADDR = '0, HWDATA = '0;
  logic [1:0]  HTRANS = '0;
  logic [2:0]  HSIZE = '0;
  logic        HREADY, HREADYOUT, HRESP;
  logic [31:0] HRDATA;
  logic        cmd_wr_en;
  logic [40:0] cmd_wr_data;
  logic        cmd_full = 1'b0;
  logic        rsp_rd_en;
  logic [31:0] rsp_data = '0;
  logic        rsp_empty = 1'b1;

  // Single-slave bus: HREADY is our own HREADYOUT.
  assign HREADY = HREADYOUT;
  always #5 HCLK = ~HCLK;

  ahb_spi_cmd_frontend #(.ADDR_BITS(8), .TIMEOUT_CYCLES(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .cmd_wr_en(cmd_wr_en), .cmd_wr_data(cmd_wr_data), .cmd_full(cmd_full),
    .rsp_rd_en(rsp_rd_en), .rsp_data(rsp_data), .rsp_empty(rsp_empty));

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- SPI side emulation: memory + in-order response FIFO ---
  logic [31:0] spi_mem [256] = '{default: 32'h0};
  logic [31:0] ref_mem [256] = '{default: 32'h0};
  logic [31:0] pdata [$];
  int          pdue  [$];
  logic [31:0] rq    [$];
  int          cyc = 0;
  int          rsp_lat = 0;
  logic        flush = 1'b0;
  logic        s_wr_en = 1'b0, s_rd_en = 1'b0, s_full = 1'b0;
  logic [40:0] s_wr_data = '0;

  always @(negedge HCLK) begin
    s_wr_en   <= cmd_wr_en;
    s_rd_en   <= rsp_rd_en;
    s_full    <= cmd_full;
    s_wr_data <= cmd_wr_data;
  end

  always @(posedge HCLK) begin
    cyc <= cyc + 1;
    if (flush) begin
      pdata.delete(); pdue.delete(); rq.delete();
      rsp_empty <= 1'b1;
    end else begin
      if (s_rd_en) begin
        chk("pop_on_empty", 64'(rq.size() != 0), 64'd1);
        if (rq.size() != 0) rsp_data <= rq.pop_front();
      end
      if (s_wr_en) begin
        chk("push_on_full", 64'(s_full), 64'd0);
        if (s_wr_data[40]) spi_mem[s_wr_data[39:32]] <= s_wr_data[31:0];
        else begin
          pdata.push_back(spi_mem[s_wr_data[39:32]]);
          pdue.push_back(cyc + rsp_lat);
        end
      end
      while (pdue.size() > 0 && pdue[0] <= cyc) begin
        rq.push_back(pdata[0]);
        pdata.delete(0);
        pdue.delete(0);
      end
      rsp_empty <= (rq.size() == 0);
    end
  end

  // ---------------- bus driver --------------------------------------------
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input int full_cyc,
                      output int waits, output int pushes, output logic [40:0] entry,
                      output int errcyc, output logic [31:0] rdata, output logic done);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = addr; HSIZE = size;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
    waits = 0; pushes = 0; entry = '0; errcyc = 0; rdata = '0; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (c > 0) begin @(posedge HCLK); #1; end
      cmd_full = (c < full_cyc);
      @(negedge HCLK);
      if (cmd_wr_en) begin pushes++; entry = cmd_wr_data; end
      if (HRESP) errcyc++;
      if (HREADYOUT) begin rdata = HRDATA; done = 1'b1; end
      else waits++;
    end
    cmd_full = 1'b0;
  endtask

  task automatic apply(input string tag, input logic wr, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] d, input int full,
                       input int e_waits, input int e_push, input logic [40:0] e_entry,
                       input int e_err, input logic [31:0] e_rdata);
    int w, p, ec;
    logic [40:0] en;
    logic [31:0] rd;
    logic dn;
    xfer(wr, a, sz, d, full, w, p, en, ec, rd, dn);
    chk({tag, "_done"},   64'(dn), 64'd1);
    chk({tag, "_waits"},  64'(w),  64'(e_waits));
    chk({tag, "_pushes"}, 64'(p),  64'(e_push));
    chk({tag, "_entry"},  64'(en), 64'(e_entry));
    chk({tag, "_errcyc"}, 64'(ec), 64'(e_err));
    chk({tag, "_rdata"},  64'(rd), 64'(e_rdata));
  endtask

  // ---------------- directed vector table ---------------------------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          full;
    int          e_waits;
    int          e_push;
    logic [40:0] e_entry;
    int          e_err;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                              input logic [31:0] d, input int full, input int ew,
                              input int ep, input logic [40:0] ee, input int er,
                              input logic [31:0] erd);
    vec_t v;
    v.wr = wr; v.addr = a; v.size = sz; v.wdata = d; v.full = full;
    v.e_waits = ew; v.e_push = ep; v.e_entry = ee; v.e_err = er; v.e_rdata = erd;
    return v;
  endfunction

  // ---------------- randomized transfers vs. transaction model ------------
  task automatic random_phase();
    int kind, full;
    logic [31:0] a, d;
    logic [2:0] sz;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      full = $urandom_range(0, 3);
      rsp_lat = $urandom_range(0, 4);
      a = $urandom();
      a[7:0] = {2'b10, 4'($urandom_range(0, 15)), 2'b00};
      d = $urandom();
      sz = 3'b010;
      if (kind == 8) a[1:0] = 2'($urandom_range(1, 3));
      if (kind == 9) begin
        sz = 3'($urandom_range(0, 7));
        if (sz == 3'b010) sz = 3'b011;
      end
      if (kind >= 8)
        apply($sformatf("rnd%0d_err", i), kind[0], a, sz, d, full, 1, 0, '0, 2, '0);
      else if (kind < 4) begin
        apply($sformatf("rnd%0d_wr", i), 1'b1, a, sz, d, full, full, 1,
              {1'b1, a[7:0], d}, 0, '0);
        ref_mem[a[7:0]] = d;
      end else
        apply($sformatf("rnd%0d_rd", i), 1'b0, a, sz, d, full, full + 2 + rsp_lat, 1,
              {1'b0, a[7:0], 32'h0}, 0, ref_mem[a[7:0]]);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic dn;
    tbl[0] = mk(1'b1, 32'h0000_0024, 3'b010, 32'h1234_5678, 0, 0, 1, {1'b1, 8'h24, 32'h1234_5678}, 0, 32'h0);
    tbl[1] = mk(1'b1, 32'h0000_0024, 3'b010, 32'h1234_5678, 5, 5, 1, {1'b1, 8'h24, 32'h1234_5678}, 0, 32'h0);
    tbl[2] = mk(1'b1, 32'h0000_0010, 3'b010, 32'hCAFE_F00D, 0, 0, 1, {1'b1, 8'h10, 32'hCAFE_F00D}, 0, 32'h0);
    tbl[3] = mk(1'b0, 32'h0000_0010, 3'b010, 32'h0,         0, 2, 1, {1'b0, 8'h10, 32'h0},         0, 32'hCAFE_F00D);
    tbl[4] = mk(1'b1, 32'h0000_0024, 3'b001, 32'hDEAD_0001, 0, 1, 0, 41'h0,                        2, 32'h0);
    tbl[5] = mk(1'b0, 32'h0000_0002, 3'b010, 32'h0,         0, 1, 0, 41'h0,                        2, 32'h0);
    tbl[6] = mk(1'b0, 32'hABCD_0024, 3'b010, 32'h0,         3, 5, 1, {1'b0, 8'h24, 32'h0},         0, 32'h1234_5678);
    tbl[7] = mk(1'b1, 32'h0000_00FC, 3'b010, 32'hA5A5_5A5A, 2, 2, 1, {1'b1, 8'hFC, 32'hA5A5_5A5A}, 0, 32'h0);
    tbl[8] = mk(1'b0, 32'h0000_00FC, 3'b000, 32'h0,         0, 1, 0, 41'h0,                        2, 32'h0);
    tbl[9] = mk(1'b0, 32'h0000_00FC, 3'b010, 32'h0,         0, 2, 1, {1'b0, 8'hFC, 32'h0},         0, 32'hA5A5_5A5A);

    // Reset state
    #2;
    chk("rst_hreadyout", 64'(HREADYOUT), 64'd1);
    chk("rst_hresp",     64'(HRESP),     64'd0);
    chk("rst_hrdata",    64'(HRDATA),    64'd0);
    chk("rst_cmd_wr_en", 64'(cmd_wr_en), 64'd0);
    chk("rst_rsp_rd_en", 64'(rsp_rd_en), 64'd0);
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;

    rsp_lat = 0;
    for (int i = 0; i < 10; i++)
      apply($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].wdata,
            tbl[i].full, tbl[i].e_waits, tbl[i].e_push, tbl[i].e_entry, tbl[i].e_err,
            tbl[i].e_rdata);

    // Back-to-back: write data phase overlapping a read address phase
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h40; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    HWDATA = 32'h0BAD_BEEF; HWRITE = 1'b0;
    @(negedge HCLK);
    chk("b2b_wr_en",    64'(cmd_wr_en),   64'd1);
    chk("b2b_wr_data",  64'(cmd_wr_data), 64'({1'b1, 8'h40, 32'h0BAD_BEEF}));
    chk("b2b_wr_ready", 64'(HREADYOUT),   64'd1);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
    chk("b2b_rd_push",  64'(cmd_wr_en),   64'd1);
    chk("b2b_rd_entry", 64'(cmd_wr_data), 64'({1'b0, 8'h40, 32'h0}));
    chk("b2b_rd_stall", 64'(HREADYOUT),   64'd0);
    dn = 1'b0;
    for (int c = 0; c < 20 && !dn; c++) begin
      @(negedge HCLK);
      if (HREADYOUT) dn = 1'b1;
    end
    chk("b2b_rd_done",  64'(dn),     64'd1);
    chk("b2b_rd_data",  64'(HRDATA), 64'h0BAD_BEEF);

    // Reset pulsed while a read waits for its response
    rsp_lat = 30;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h14; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("rdwait_stall", 64'(HREADYOUT), 64'd0);
    #2 HRESETn = 1'b0;
    #1;
    chk("mid_rst_hreadyout", 64'(HREADYOUT), 64'd1);
    chk("mid_rst_hrdata",    64'(HRDATA),    64'd0);
    chk("mid_rst_hresp",     64'(HRESP),     64'd0);
    chk("mid_rst_wr_en",     64'(cmd_wr_en), 64'd0);
    @(posedge HCLK); #1;
    flush = 1'b1;
    @(posedge HCLK); #1;
    flush = 1'b0;
    HRESETn = 1'b1;
    rsp_lat = 0;
    apply("post_rst_wr", 1'b1, 32'h14, 3'b010, 32'h5555_AAAA, 0, 0, 1,
          {1'b1, 8'h14, 32'h5555_AAAA}, 0, 32'h0);

`ifdef AHB_RD_TIMEOUT_EN
    apply("tmo_wr20", 1'b1, 32'h20, 3'b010, 32'h1111_1111, 0, 0, 1, {1'b1, 8'h20, 32'h1111_1111}, 0, 32'h0);
    apply("tmo_wr30", 1'b1, 32'h30, 3'b010, 32'h2222_2222, 0, 0, 1, {1'b1, 8'h30, 32'h2222_2222}, 0, 32'h0);
    // Push, 16 wait cycles, then the two ERROR cycles.
    rsp_lat = 25;
    apply("tmo_rd20", 1'b0, 32'h20, 3'b010, 32'h0, 0, 18, 1, {1'b0, 8'h20, 32'h0}, 2, 32'h0);
    rsp_lat = 0;
    begin
      int w, p, ec;
      logic [40:0] en;
      logic [31:0] rd;
      xfer(1'b0, 32'h30, 3'b010, 32'h0, 0, w, p, en, ec, rd, dn);
      chk("tmo_rd30_done",  64'(dn), 64'd1);
      chk("tmo_rd30_err",   64'(ec), 64'd0);
      chk("tmo_rd30_rdata", 64'(rd), 64'h2222_2222);
    end
`endif

    random_phase();

    repeat (2) @(posedge HCLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
